sub_bytes_seq: RTL
==================

// Module: sub_bytes_seq
// PURPOSE
//  Multi-cycle, handshaked AES SubBytes engine for one 128-bit state.
//  LANES parallel S-box lookups are shared across the 16 bytes over 16/LANES cycles.
//  Trades area for latency against the flat 16-S-box combinational SubBytes.
//  Sits between AddRoundKey and ShiftRows in iterative (area-optimised) AES cores.
// PARAMETERS
//  LANES  4  S-box instances / bytes per cycle; legal 1,2,4,8,16 (else $error at elaboration)
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    instate/inv valid
//  in_ready   out  1    engine can accept a state
//  instate    in   128  input state; byte k = instate[8k+7:8k], k=0..15
//  inv        in   1    1 = inverse S-box (only used with SUBBYTES_INV_EN)
//  out_valid  out  1    outstate valid, held until out_ready
//  out_ready  in   1    downstream accepts outstate
//  outstate   out  128  substituted state, same byte mapping
//  busy       out  1    state != IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, busy=0,
//    outstate=0, batch counter=0, latched mode=0. Reset mid-operation aborts
//    the transaction; no partial result is ever presented.
//  - N = 16/LANES batches. Counter width = max(1,$clog2(N)).
//  - FSM: IDLE -> BUSY on in_valid&in_ready; instate and inv latched on that edge.
//    BUSY: each cycle substitutes bytes [c*LANES .. c*LANES+LANES-1] (c = counter)
//    into a 128-bit working register, c increments; after batch N-1 -> DONE, c=0.
//    DONE: out_valid=1; on out_ready -> IDLE.
//  - in_ready = (state==IDLE). One idle bubble between transactions.
//  - Latency: accept edge to out_valid high = N cycles (LANES=4: 4; LANES=16: 1).
//  - outstate/out_valid stable while out_valid&!out_ready (no drop, no change).
//  - in_valid ignored outside IDLE; instate/inv changes after accept have no effect.
//  - Bytes not yet processed in BUSY are don't-care on outstate; outstate is
//    only defined while out_valid=1.
//  - S-box: FIPS-197 forward table; lookup index = full byte {hi nibble, lo nibble}.
// CONFIGURATION
//  SUBBYTES_INV_EN defined: LANES inverse S-box tables added; mode latched from inv
//    at accept selects forward (0) or inverse (1) for the entire transaction.
//  Not defined: inverse tables absent, inv port present but ignored, always forward.
// TESTING
//  1. rst_n=0 then 1, no stimulus -> in_ready=1, out_valid=0, busy=0, outstate=0.
//  2. LANES=4, instate=0, inv=0 -> out_valid 4 cycles after accept, outstate=32'h63636363 x4.
//  3. instate=128'h00112233445566778899aabbccddeeff -> outstate=
//     128'h638293c31bfc33f5c4eeacea4bc12816 for every legal LANES; latency 16/LANES.
//  4. out_ready=0 for 10 cycles in DONE -> outstate/out_valid stable, in_ready=0;
//     out_ready=1 -> IDLE next cycle, in_ready=1; in_valid pulses during BUSY ignored.
//  5. rst_n pulsed low in BUSY batch 2 -> outputs to reset values immediately;
//     next transaction (instate=0) returns 63 x16 with normal latency.
//  6. SUBBYTES_INV_EN, inv=1, instate=128'h638293c31bfc33f5c4eeacea4bc12816 ->
//     outstate=128'h00112233445566778899aabbccddeeff; same stimulus without macro -> forward result.

Source files
------------

// File: rtl/sub_bytes_seq.sv
// Multi-cycle AES SubBytes: LANES S-box lookups per cycle, 16/LANES cycles from accept to out_valid.
// Result held until out_ready; in_ready only in IDLE. Define SUBBYTES_INV_EN to add inverse S-box mode.
module sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] instate,
  input  logic         inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] outstate,
  output logic         busy
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  // Row r of the table holds entries 16r..16r+15, entry 0 leftmost.
  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SUBBYTES_INV_EN
  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  logic mode_q, mode_d;
`else
  logic unused_inv;
  assign unused_inv = inv;
`endif

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  work_q, work_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
`ifdef SUBBYTES_INV_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          cnt_d   = '0;
          work_d  = instate;
`ifdef SUBBYTES_INV_EN
          mode_d  = inv;
`endif
        end
      end
      BUSY: begin
        // Batch c covers bytes c*LANES .. c*LANES+LANES-1, substituted in place.
        for (int l = 0; l < LANES; l++) begin
`ifdef SUBBYTES_INV_EN
          work_d[(int'(cnt_q) * LANES + l) * 8 +: 8] =
            mode_q ? SBOX_INV[work_q[(int'(cnt_q) * LANES + l) * 8 +: 8]]
                   : SBOX_FWD[work_q[(int'(cnt_q) * LANES + l) * 8 +: 8]];
`else
          work_d[(int'(cnt_q) * LANES + l) * 8 +: 8] =
            SBOX_FWD[work_q[(int'(cnt_q) * LANES + l) * 8 +: 8]];
`endif
        end
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
`ifdef SUBBYTES_INV_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
`ifdef SUBBYTES_INV_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign outstate  = work_q;

endmodule
